// File: rtl/div_mul_s2p_core.sv
// div_mul_s2p_core: restoring divider, serial-to-parallel converter and registered multiplier
module div_mul_s2p_core #(
    parameter int DW = 26,
    parameter int VW = 14,
    parameter int MW = 13,
    parameter int SW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_en,
    input  logic [DW-1:0]     dividend,
    input  logic [VW-1:0]     divisor,
    output logic [DW-1:0]     quotient,
    output logic              divider_ok,
    input  logic              s2p_en,
    input  logic              dext,
    output logic [SW-1:0]     dout,
    output logic              dout_valid,
    input  logic              mul_en,
    input  logic [DW-1:0]     multi1,
    input  logic [MW-1:0]     multi2,
    output logic [DW+MW-1:0]  product
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state;
    logic [4:0]    cnt;
    logic [DW-1:0] dq;
    logic [VW-1:0] dvs;
    logic [VW-1:0] rem;
    logic [VW:0]   rem_sh;
    logic [VW-1:0] rem_nx;
    logic          q_bit;
    logic [SW-1:0] sr;
    logic [3:0]    bcnt;
    // dq holds the not-yet-consumed dividend bits and collects quotient bits from the right;
    // the remainder always stays below the divisor, so it fits VW bits between steps
    assign rem_sh = {rem, dq[DW-1]};
    assign q_bit  = rem_sh >= {1'b0, dvs};
    assign rem_nx = q_bit ? VW'(rem_sh - {1'b0, dvs}) : rem_sh[VW-1:0];
    // divider FSM: capture in IDLE, one restoring step per cycle in BUSY, abort when div_en drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dq         <= '0;
            dvs        <= '0;
            rem        <= '0;
            quotient   <= '0;
            divider_ok <= 1'b0;
        end else begin
            divider_ok <= 1'b0;
            if (state == IDLE) begin
                if (div_en) begin
                    dq    <= dividend;
                    dvs   <= divisor;
                    rem   <= '0;
                    cnt   <= '0;
                    state <= BUSY;
                end
            end else if (!div_en) begin
                state <= IDLE;
            end else begin
                rem <= rem_nx;
                dq  <= {dq[DW-2:0], q_bit};
                cnt <= cnt + 5'd1;
                if (cnt == 5'(DW-1)) begin
                    quotient   <= {dq[DW-2:0], q_bit};
                    divider_ok <= 1'b1;
                    state      <= IDLE;
                end
            end
        end
    end
    // serial-to-parallel: MSB-first framing, realigned whenever s2p_en drops
    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            bcnt       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (s2p_en) begin
                sr   <= {sr[SW-2:0], dext};
                bcnt <= (bcnt == 4'(SW-1)) ? 4'd0 : bcnt + 4'd1;
                if (bcnt == 4'(SW-1)) begin
                    dout       <= {sr[SW-2:0], dext};
                    dout_valid <= 1'b1;
                end
            end else begin
                bcnt <= '0;
            end
        end
    end
    // full-width registered product, held while mul_en is low
    always_ff @(posedge clk) begin
        if (rst) product <= '0;
        else if (mul_en) product <= (DW+MW)'(multi1) * (DW+MW)'(multi2);
    end
endmodule

// File: tb/tb_div_mul_s2p_core.sv
// tb_div_mul_s2p_core: randomized self-checking bench with a behavioural reference model
module tb_div_mul_s2p_core;
    logic        clk = 0;
    logic        rst = 1;
    logic        div_en = 0;
    logic [25:0] dividend = 0;
    logic [13:0] divisor = 0;
    logic [25:0] quotient;
    logic        divider_ok;
    logic        s2p_en = 0;
    logic        dext = 0;
    logic [9:0]  dout;
    logic        dout_valid;
    logic        mul_en = 0;
    logic [25:0] multi1 = 0;
    logic [12:0] multi2 = 0;
    logic [38:0] product;

    int checks = 0;
    int failures = 0;
    bit          sq[$];
    logic [9:0]  m_dout = 0;
    logic [38:0] m_prod = 0;
    logic [25:0] m_quot = 0;

    div_mul_s2p_core dut (
        .clk(clk), .rst(rst), .div_en(div_en), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .divider_ok(divider_ok), .s2p_en(s2p_en), .dext(dext),
        .dout(dout), .dout_valid(dout_valid), .mul_en(mul_en), .multi1(multi1),
        .multi2(multi2), .product(product)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] ref_div(input logic [25:0] a, input logic [13:0] b);
        return (b == 0) ? 26'h3FFFFFF : 26'(a / b);
    endfunction

    function automatic logic [38:0] ref_mul(input logic [25:0] a, input logic [12:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[38:0];
    endfunction

    task automatic model_reset();
        sq.delete();
        m_dout = 0;
        m_prod = 0;
        m_quot = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({quotient, divider_ok, dout, dout_valid, product} !== '0) begin
            failures++;
            $display("FAIL reset: q=%h ok=%b dout=%h dv=%b prod=%h, required all zero",
                     quotient, divider_ok, dout, dout_valid, product);
        end
        rst = 0;
    endtask

    task automatic mul_step(input logic en, input logic [25:0] a, input logic [12:0] b, input string name);
        mul_en = en; multi1 = a; multi2 = b;
        @(posedge clk); #1;
        if (en) m_prod = ref_mul(a, b);
        checks++;
        if (product !== m_prod) begin
            failures++;
            $display("FAIL %s: product=%h required %h", name, product, m_prod);
        end
    endtask

    task automatic test_mul();
        mul_step(1, 26'd4096, 13'd4095, "mul_4096x4095");
        mul_step(1, 26'h3FFFFFF, 13'h1FFF, "mul_max");
        for (int i = 0; i < 8; i++)
            mul_step(1, 26'($urandom), 13'($urandom), "mul_rand");
        for (int i = 0; i < 4; i++)
            mul_step(0, 26'($urandom), 13'($urandom), "mul_hold");
        mul_en = 0;
    endtask

    task automatic s2p_step(input logic en, input logic b, input string name);
        logic       exp_v;
        logic [9:0] v;
        s2p_en = en; dext = b;
        @(posedge clk); #1;
        exp_v = 0;
        if (!en) sq.delete();
        else begin
            sq.push_back(b);
            if (sq.size() == 10) begin
                v = 0;
                foreach (sq[i]) v = {v[8:0], sq[i]};
                m_dout = v;
                exp_v = 1;
                sq.delete();
            end
        end
        checks++;
        if (dout_valid !== exp_v || dout !== m_dout) begin
            failures++;
            $display("FAIL %s: dout=%h valid=%b required dout=%h valid=%b", name, dout, dout_valid, m_dout, exp_v);
        end
    endtask

    task automatic test_s2p();
        logic [9:0] pat;
        pat = 10'b1011001011;
        for (int i = 9; i >= 0; i--) s2p_step(1, pat[i], "s2p_frame_2cb");
        checks++;
        if (dout !== 10'h2CB) begin
            failures++;
            $display("FAIL s2p_const: dout=%h required 2cb", dout);
        end
        for (int i = 0; i < 4; i++) s2p_step(1, 1'($urandom), "s2p_partial");
        s2p_step(0, 1, "s2p_realign");
        for (int i = 0; i < 25; i++) s2p_step(1, 1'($urandom), "s2p_rand");
        for (int i = 0; i < 40; i++) s2p_step(1'($urandom_range(0, 7) != 0), 1'($urandom), "s2p_gaps");
        s2p_en = 0;
    endtask

    task automatic run_div(input logic [25:0] a, input logic [13:0] b, input string name);
        dividend = a; divisor = b; div_en = 1;
        @(posedge clk); #1;
        for (int n = 1; n <= 26; n++) begin
            dividend = 26'($urandom); divisor = 14'($urandom);
            @(posedge clk); #1;
            checks++;
            if (divider_ok !== (n == 26)) begin
                failures++;
                $display("FAIL %s_ok_timing: step %0d divider_ok=%b required %b", name, n, divider_ok, n == 26);
            end
        end
        m_quot = ref_div(a, b);
        checks++;
        if (quotient !== m_quot) begin
            failures++;
            $display("FAIL %s: quotient=%h required %h (a=%0d b=%0d)", name, quotient, m_quot, a, b);
        end
        div_en = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        logic [25:0] a, b, c;
        run_div(26'd16384000, 14'd4000, "div_basic");
        run_div(26'h3FFFFFF, 14'd0, "div_zero");
        run_div(26'd0, 14'd1, "div_zero_dividend");
        run_div(26'h3FFFFFF, 14'h3FFF, "div_max");
        for (int i = 0; i < 6; i++) run_div(26'($urandom), 14'($urandom), "div_rand");
        for (int i = 0; i < 3; i++) run_div(26'($urandom), 14'($urandom_range(1, 15)), "div_small");
        for (int i = 0; i < 3; i++) begin
            a = 26'($urandom_range(0, 2000)); b = 26'($urandom_range(0, 2000)); c = 26'($urandom_range(1, 2000));
            run_div(a << 14, 14'(a + b + c), "div_ratio");
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        dividend = 26'h3FFFFFF; divisor = 0; div_en = 1;
        @(posedge clk); #1;
        pulses = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            checks++;
            if (divider_ok !== ((e % 27) == 26)) begin
                failures++;
                $display("FAIL b2b_period: edge %0d divider_ok=%b required %b", e, divider_ok, (e % 27) == 26);
            end
            if (divider_ok) pulses++;
        end
        m_quot = 26'h3FFFFFF;
        checks++;
        if (pulses != 2 || quotient !== m_quot) begin
            failures++;
            $display("FAIL b2b_result: pulses=%0d quotient=%h required 2 and %h", pulses, quotient, m_quot);
        end
        div_en = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int seen;
        run_div(26'd123456, 14'd77, "abort_prep");
        dividend = 26'd999999; divisor = 14'd3; div_en = 1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        div_en = 0;
        seen = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (divider_ok) seen++;
        end
        checks++;
        if (seen != 0 || quotient !== m_quot) begin
            failures++;
            $display("FAIL abort: pulses=%0d quotient=%h required 0 and %h", seen, quotient, m_quot);
        end
    endtask

    task automatic test_reset_mid_busy();
        mul_step(1, 26'd5, 13'd7, "mul_before_rst");
        mul_en = 0;
        dividend = 26'd500000; divisor = 14'd9; div_en = 1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        model_reset();
        checks++;
        if ({quotient, divider_ok, dout, dout_valid, product} !== '0) begin
            failures++;
            $display("FAIL rst_mid_busy: q=%h ok=%b dout=%h prod=%h required all zero", quotient, divider_ok, dout, product);
        end
        rst = 0;
        run_div(26'd500000, 14'd9, "div_after_rst");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_s2p();
        test_div();
        test_back_to_back();
        test_abort();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
